// File: rtl/fruit_ctrl_n_if.sv
// Bus between the lane detection logic, the fruit controller and the lane
// sprite generators. The testbench or detection side uses the master modport;
// the controller uses the slave modport.
//
// Handshake: chk is a request strobe and busy is its acknowledge/back-pressure.
// A rising edge of chk is accepted only when the controller is idle (busy=0,
// state IDLE). ac/d must be held stable from the chk edge through the
// following cycle, when the round is evaluated. Edges that arrive while
// busy=1, or after game over, are dropped rather than queued. rs is a
// one-cycle pulse with no back-pressure.
interface fruit_ctrl_n_if #(
  parameter int LANES   = 3,
  parameter int SCORE_W = 10,
  parameter int MISS_W  = 8
);
  logic               chk;
  logic [LANES-1:0]   ac;
  logic [LANES-1:0]   d;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  missed;
  logic [1:0]         level;
  logic [LANES-1:0]   rs;
  logic               go;
  logic               max;
  logic               busy;
  logic [2:0]         state;   // FSM state, exported for debug and checkers

  modport master (
    output chk, ac, d,
    input  score, missed, level, rs, go, max, busy, state
  );

  modport slave (
    input  chk, ac, d,
    output score, missed, level, rs, go, max, busy, state
  );
endinterface

// File: rtl/fruit_ctrl_n.sv
// Multi-lane fruit game controller: scoring with a combo multiplier, miss
// counting, three-level progression, respawn sequencing (one lane per cycle)
// and game-over / win. A round is evaluated on each accepted chk rising edge.
module fruit_ctrl_n #(
  parameter int LANES     = 3,
  parameter int SCORE_W   = 10,
  parameter int MISS_W    = 8,
  parameter int L0_MAX    = 24,
  parameter int L1_MAX    = 99,
  parameter int L2_MAX    = 199,
  parameter int L0_MISS   = 7,
  parameter int L1_MISS   = 31,
  parameter int L2_MISS   = 63,
  parameter int COMBO_LEN = 4
) (
  input  logic           clk,
  input  logic           on,
  fruit_ctrl_n_if.slave  bus
);

  localparam int CW = $clog2(COMBO_LEN + 1);

  localparam logic [SCORE_W-1:0] L0_MAX_W    = SCORE_W'(L0_MAX);
  localparam logic [SCORE_W-1:0] L1_MAX_W    = SCORE_W'(L1_MAX);
  localparam logic [SCORE_W-1:0] L2_MAX_W    = SCORE_W'(L2_MAX);
  localparam logic [MISS_W-1:0]  L0_MISS_W   = MISS_W'(L0_MISS);
  localparam logic [MISS_W-1:0]  L1_MISS_W   = MISS_W'(L1_MISS);
  localparam logic [MISS_W-1:0]  L2_MISS_W   = MISS_W'(L2_MISS);
  localparam logic [CW-1:0]      COMBO_MAX   = CW'(COMBO_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVAL    = 3'd1,
    RESPAWN = 3'd2,
    LEVELUP = 3'd3,
    OVER    = 3'd4,
    WIN     = 3'd5
  } state_t;

  state_t             state;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  missed;
  logic [1:0]         level;
  logic [LANES-1:0]   rs;
  logic               go;
  logic               max_q;
  logic               busy;
  logic [CW-1:0]      combo;
  logic [LANES-1:0]   pend;
  logic               grace_used;   // 0 until the first round after reset is evaluated
  logic               prevchk;

  // Round evaluation terms, all derived from the current level and lane flags
  logic [LANES-1:0]   act;          // lanes active at the current level
  logic [LANES-1:0]   act_up;       // lanes active at the next level
  logic [LANES-1:0]   hm;           // lanes hit or missed this round
  logic [LANES-1:0]   low;          // lowest pending lane
  logic [3:0]         h;
  logic [3:0]         m;
  logic [SCORE_W-1:0] pts;
  logic [SCORE_W:0]   score_sum;
  logic [MISS_W:0]    miss_sum;
  logic [SCORE_W-1:0] score_new;
  logic [MISS_W-1:0]  missed_new;
  logic [SCORE_W-1:0] lmax;
  logic [MISS_W-1:0]  lim;

  // Combinational round arithmetic: counts, points, saturation, thresholds
  always_comb begin
    act    = '0;
    act_up = '0;
    h      = '0;
    m      = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i <= int'(level))     act[i]    = 1'b1;
      if (i <= int'(level) + 1) act_up[i] = 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      if (act[i]) begin
        if (bus.ac[i] && bus.d[i]) h = h + 4'd1;
        if (!bus.ac[i])            m = m + 4'd1;
      end
    end
    // Misses in the very first round are forgiven (the lanes still respawn)
    if (!grace_used) m = '0;
    hm  = act & (bus.d | ~bus.ac);
    low = pend & (~pend + LANES'(1));

    pts        = (combo >= COMBO_MAX) ? SCORE_W'({h, 1'b0}) : SCORE_W'(h);
    score_sum  = {1'b0, score} + {1'b0, pts};
    score_new  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    miss_sum   = {1'b0, missed} + (MISS_W + 1)'(m);
    missed_new = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];

    case (level)
      2'd0:    begin lmax = L0_MAX_W; lim = L0_MISS_W; end
      2'd1:    begin lmax = L1_MAX_W; lim = L1_MISS_W; end
      default: begin lmax = L2_MAX_W; lim = L2_MISS_W; end
    endcase
  end

  // Game FSM with registered outputs; OVER and WIN hold until reset
  always_ff @(posedge clk or negedge on) begin
    if (!on) begin
      state      <= IDLE;
      score      <= '0;
      missed     <= '0;
      level      <= '0;
      rs         <= '0;
      go         <= 1'b0;
      max_q      <= 1'b0;
      busy       <= 1'b0;
      combo      <= '0;
      pend       <= '0;
      grace_used <= 1'b0;
      prevchk    <= 1'b0;
    end else begin
      prevchk <= bus.chk;
      rs      <= '0;
      case (state)
        IDLE: begin
          if (bus.chk && !prevchk) begin
            state <= EVAL;
            busy  <= 1'b1;
          end
        end
        EVAL: begin
          score      <= score_new;
          missed     <= missed_new;
          grace_used <= 1'b1;
          pend       <= hm;
          if (m != 4'd0)
            combo <= '0;
          else if (h != 4'd0 && combo < COMBO_MAX)
            combo <= combo + CW'(1);
          // Loss outranks win, win outranks level-up
          if (missed_new > lim) begin
            state <= OVER;
            go    <= 1'b1;
            busy  <= 1'b0;
          end else if (level == 2'd2 && score_new > L2_MAX_W) begin
            state <= WIN;
            go    <= 1'b1;
            max_q <= 1'b1;
            busy  <= 1'b0;
          end else if (level != 2'd2 && score_new > lmax) begin
            state <= LEVELUP;
          end else if (hm != '0) begin
            state <= RESPAWN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LEVELUP: begin
          level <= level + 2'd1;
          pend  <= act_up;
          combo <= '0;
          state <= RESPAWN;
        end
        RESPAWN: begin
          rs   <= low;
          pend <= pend & ~low;
          if ((pend & ~low) == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        OVER: state <= OVER;
        WIN:  state <= WIN;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score  = score;
  assign bus.missed = missed;
  assign bus.level  = level;
  assign bus.rs     = rs;
  assign bus.go     = go;
  assign bus.max    = max_q;
  assign bus.busy   = busy;
  assign bus.state  = state;

endmodule

// File: tb/tb_fruit_ctrl_n.sv
// Directed bench for fruit_ctrl_n. A round-level game model predicts the
// score/missed/level/flags after each round and the ordered rs pulses, which
// are queued and popped as the controller emits them.
module tb_fruit_ctrl_n;
  localparam int LANES   = 3;
  localparam int SCORE_W = 10;
  localparam int MISS_W  = 8;

  logic clk = 1'b0;
  logic on  = 1'b1;

  fruit_ctrl_n_if #(.LANES(LANES), .SCORE_W(SCORE_W), .MISS_W(MISS_W)) bus ();

  fruit_ctrl_n #(.LANES(LANES), .SCORE_W(SCORE_W), .MISS_W(MISS_W)) dut (
    .clk (clk),
    .on  (on),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard and model state
  logic [LANES-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int m_score, m_missed, m_level, m_combo, exp_first;
  bit m_grace_used, m_over, m_win;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lim_of(input int lv);
    return (lv == 0) ? 7 : (lv == 1) ? 31 : 63;
  endfunction

  function automatic int lmax_of(input int lv);
    return (lv == 0) ? 24 : (lv == 1) ? 99 : 199;
  endfunction

  task automatic model_reset();
    m_score = 0; m_missed = 0; m_level = 0; m_combo = 0;
    m_grace_used = 0; m_over = 0; m_win = 0;
    exp_q.delete();
  endtask

  // Game rules at round granularity; queues the rs pulses in lane order
  task automatic model_round(input logic [LANES-1:0] a, input logic [LANES-1:0] dd);
    int na, h, mm, p;
    logic [LANES-1:0] pend, oh;
    exp_first = -1;
    if (m_over || m_win) return;
    na = (m_level + 1 < LANES) ? m_level + 1 : LANES;
    h = 0; mm = 0; pend = '0;
    for (int i = 0; i < na; i++) begin
      if (a[i] && dd[i]) begin h++; pend[i] = 1'b1; end
      else if (!a[i]) begin mm++; pend[i] = 1'b1; end
    end
    if (!m_grace_used) mm = 0;
    m_grace_used = 1;
    p = (m_combo >= 4) ? 2 * h : h;
    m_score  = (m_score + p > 1023) ? 1023 : m_score + p;
    m_missed = (m_missed + mm > 255) ? 255 : m_missed + mm;
    if (mm > 0) m_combo = 0;
    else if (h > 0 && m_combo < 4) m_combo++;
    if (m_missed > lim_of(m_level)) m_over = 1;
    else if (m_level == 2 && m_score > 199) m_win = 1;
    else if (m_score > lmax_of(m_level)) begin
      m_level++;
      m_combo = 0;
      exp_first = 2;
      na = (m_level + 1 < LANES) ? m_level + 1 : LANES;
      for (int i = 0; i < na; i++) begin
        oh = '0; oh[i] = 1'b1; exp_q.push_back(oh);
      end
    end else begin
      if (pend != '0) exp_first = 1;
      for (int i = 0; i < LANES; i++) begin
        if (pend[i]) begin oh = '0; oh[i] = 1'b1; exp_q.push_back(oh); end
      end
    end
  endtask

  task automatic check_totals();
    check("score",  bus.score,  m_score);
    check("missed", bus.missed, m_missed);
    check("level",  bus.level,  m_level);
    check("go",     bus.go,     m_over || m_win);
    check("max",    bus.max,    m_win);
  endtask

  task automatic do_reset();
    bus.chk = 1'b0; bus.ac = '0; bus.d = '0;
    #1 on = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_score", bus.score, 0);
    check("rst_missed", bus.missed, 0);
    check("rst_level", bus.level, 0);
    check("rst_flags", {bus.go, bus.max, bus.busy}, 0);
    check("rst_rs", bus.rs, 0);
    check("rst_state", bus.state, 0);
    @(negedge clk);
    on = 1'b1;
    model_reset();
  endtask

  // Driver: one round; optionally re-pulse chk while the controller is busy
  task automatic round(input logic [LANES-1:0] a, input logic [LANES-1:0] dd, input bit extra);
    bit was_live;
    int first_k;
    logic [LANES-1:0] e;
    was_live = !(m_over || m_win);
    model_round(a, dd);
    @(negedge clk);
    bus.ac = a; bus.d = dd; bus.chk = 1'b1;
    @(negedge clk);
    bus.chk = 1'b0;
    check(was_live ? "busy_eval" : "busy_ignored", bus.busy, was_live);
    first_k = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (extra && k == 0) bus.chk = 1'b1;
      if (extra && k == 1) bus.chk = 1'b0;
      if (bus.rs != '0) begin
        if (first_k < 0) first_k = k;
        if (exp_q.size() == 0) check("rs_unexpected", bus.rs, 0);
        else begin
          e = exp_q.pop_front();
          check("rs_pulse", bus.rs, e);
        end
      end
    end
    check("rs_missing", exp_q.size(), 0);
    exp_q.delete();
    if (exp_first >= 0) check("rs_latency", first_k, exp_first);
    check("busy_end", bus.busy, 0);
    check_totals();
  endtask

  initial begin
    int cnt;
    bus.chk = 1'b0; bus.ac = '0; bus.d = '0;
    model_reset();

    // Reset asserted between edges while respawning
    do_reset();
    repeat (6) round(3'b001, 3'b001, 1'b0);
    model_round(3'b001, 3'b001);
    @(negedge clk);
    bus.ac = 3'b001; bus.d = 3'b001; bus.chk = 1'b1;
    @(negedge clk);
    bus.chk = 1'b0;
    @(negedge clk);
    check("pre_rst_score", bus.score, m_score);
    check("pre_rst_state", bus.state, 2);
    #2 on = 1'b0;
    #1;
    check("async_score", bus.score, 0);
    check("async_rs", bus.rs, 0);
    check("async_busy", bus.busy, 0);
    check("async_level", bus.level, 0);
    do_reset();
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rs != '0) cnt++;
    end
    check("idle_rs", cnt, 0);

    // Level 0 to level 1, then combo at level 1 (with a dropped busy chk)
    repeat (15) round(3'b001, 3'b001, 1'b0);
    check("lvl1", bus.level, 1);
    round(3'b011, 3'b011, 1'b1);
    repeat (4) round(3'b011, 3'b011, 1'b0);
    round(3'b001, 3'b001, 1'b0);

    // Precedence: loss beats level-up in the same round
    repeat (31) round(3'b011, 3'b001, 1'b0);
    repeat (30) round(3'b001, 3'b000, 1'b0);
    round(3'b011, 3'b001, 1'b0);
    round(3'b001, 3'b001, 1'b0);
    check("prec_go", bus.go, 1);
    check("prec_level", bus.level, 1);
    round(3'b001, 3'b001, 1'b0);

    // Grace round, then loss at level 0, then ignored chk
    do_reset();
    round(3'b000, 3'b000, 1'b0);
    repeat (8) round(3'b000, 3'b000, 1'b0);
    check("over_state", bus.state, 4);
    round(3'b001, 3'b001, 1'b0);

    // Climb to level 2 and win
    do_reset();
    repeat (15) round(3'b001, 3'b001, 1'b0);
    repeat (21) round(3'b011, 3'b011, 1'b0);
    check("lvl2", bus.level, 2);
    repeat (49) round(3'b111, 3'b001, 1'b0);
    round(3'b011, 3'b000, 1'b0);
    repeat (2) round(3'b111, 3'b001, 1'b0);
    round(3'b111, 3'b111, 1'b1);
    check("win_state", bus.state, 5);
    round(3'b111, 3'b111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
